maxpool_seq_ctrl: RTL and testbench

MAXPOOL_SEQ_CTRL -- requirements
Module: maxpool_seq_ctrl

---
 rtl/maxpool_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_maxpool_seq_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_seq_ctrl.sv
// Sequential max-pool controller: walks every pooling window, reads one pixel per cycle and
// streams each window maximum. Define MAXPOOL_SIGNED_EN for two's-complement pixel compares.
module maxpool_seq_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IN_HEIGHT  = 28,
  parameter int unsigned IN_WIDTH   = 28,
  parameter int unsigned CHANNELS   = 1,
  parameter int unsigned POOL_SIZE  = 2,
  parameter int unsigned STRIDE     = 2,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr
);

  localparam logic [ADDR_WIDTH-1:0] InH    = ADDR_WIDTH'(IN_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] InW    = ADDR_WIDTH'(IN_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] Ch     = ADDR_WIDTH'(CHANNELS);
  localparam logic [ADDR_WIDTH-1:0] Pool   = ADDR_WIDTH'(POOL_SIZE);
  localparam logic [ADDR_WIDTH-1:0] Stride = ADDR_WIDTH'(STRIDE);
  localparam logic [ADDR_WIDTH-1:0] OutH   = ADDR_WIDTH'(IN_HEIGHT / STRIDE);
  localparam logic [ADDR_WIDTH-1:0] OutW   = ADDR_WIDTH'(IN_WIDTH / STRIDE);
  localparam logic [ADDR_WIDTH-1:0] AOne   = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {StIdle, StRead, StWait, StEmit, StDone} state_e;

  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] c_q, oh_q, ow_q, i_q, j_q;
  logic [DATA_WIDTH-1:0] max_q;
  logic                  pend_q, first_q;

  logic [ADDR_WIDTH-1:0] row_base, col_base, rows_n, cols_n, elem_addr, win_addr;
  logic                  last_col, last_elem, last_ow, last_oh, last_c, last_win, greater;

  // Out-of-range rows/columns are clipped from the window extent, so skipped elements cost
  // no cycles.
  always_comb begin
    row_base  = oh_q * Stride;
    col_base  = ow_q * Stride;
    rows_n    = (row_base + Pool > InH) ? InH - row_base : Pool;
    cols_n    = (col_base + Pool > InW) ? InW - col_base : Pool;
    last_col  = (j_q == cols_n - AOne);
    last_elem = last_col && (i_q == rows_n - AOne);
    last_ow   = (ow_q == OutW - AOne);
    last_oh   = (oh_q == OutH - AOne);
    last_c    = (c_q == Ch - AOne);
    last_win  = last_ow && last_oh && last_c;
    elem_addr = c_q * InH * InW + (row_base + i_q) * InW + col_base + j_q;
    win_addr  = c_q * OutH * OutW + oh_q * OutW + ow_q;
  end

`ifdef MAXPOOL_SIGNED_EN
  assign greater = $signed(rd_data) > $signed(max_q);
`else
  assign greater = rd_data > max_q;
`endif

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_addr  = '0;
    unique case (state_q)
      StIdle: if (start) state_d = StRead;
      StRead: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = elem_addr;
        if (last_elem) state_d = StWait;
      end
      StWait: begin
        busy    = 1'b1;
        state_d = StEmit;
      end
      StEmit: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = max_q;
        out_addr  = win_addr;
        if (out_ready) state_d = last_win ? StDone : StRead;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      c_q     <= '0;
      oh_q    <= '0;
      ow_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            c_q  <= '0;
            oh_q <= '0;
            ow_q <= '0;
            i_q  <= '0;
            j_q  <= '0;
          end
        end
        StRead: begin
          if (!last_elem) begin
            if (last_col) begin
              j_q <= '0;
              i_q <= i_q + AOne;
            end else begin
              j_q <= j_q + AOne;
            end
          end
        end
        StEmit: begin
          if (out_ready) begin
            i_q <= '0;
            j_q <= '0;
            if (last_win) begin
              c_q  <= '0;
              oh_q <= '0;
              ow_q <= '0;
            end else if (last_ow) begin
              ow_q <= '0;
              if (last_oh) begin
                oh_q <= '0;
                c_q  <= c_q + AOne;
              end else begin
                oh_q <= oh_q + AOne;
              end
            end else begin
              ow_q <= ow_q + AOne;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Read data lags rd_en by one cycle; first_q marks the window's first returned element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= 1'b0;
      first_q <= 1'b0;
      max_q   <= '0;
    end else begin
      pend_q  <= (state_q == StRead);
      first_q <= (state_q == StRead) && (i_q == '0) && (j_q == '0);
      if (first_q) begin
        max_q <= rd_data;
      end else if (pend_q && greater) begin
        max_q <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_seq_ctrl.sv
// Directed bench for maxpool_seq_ctrl: a loop-based window model fills read/output scoreboards.
// Instance a is a 4x4x1 2x2/2 map, instance b a 4x4x2 3x3/2 map with clipped windows.
module tb_maxpool_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [0:63];

  logic        start_a = 1'b0, out_ready_a = 1'b1;
  logic        busy_a, done_a, rd_en_a, out_valid_a;
  logic [15:0] rd_addr_a, out_addr_a;
  logic [7:0]  rd_data_a, out_data_a;

  logic        start_b = 1'b0, out_ready_b = 1'b1;
  logic        busy_b, done_b, rd_en_b, out_valid_b;
  logic [15:0] rd_addr_b, out_addr_b;
  logic [7:0]  rd_data_b, out_data_b;

  maxpool_seq_ctrl #(
    .DATA_WIDTH(8), .IN_HEIGHT(4), .IN_WIDTH(4), .CHANNELS(1),
    .POOL_SIZE(2), .STRIDE(2), .ADDR_WIDTH(16)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .out_addr(out_addr_a)
  );

  maxpool_seq_ctrl #(
    .DATA_WIDTH(8), .IN_HEIGHT(4), .IN_WIDTH(4), .CHANNELS(2),
    .POOL_SIZE(3), .STRIDE(2), .ADDR_WIDTH(16)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_addr(out_addr_b)
  );

  // Memory answers one cycle after rd_en; garbage otherwise so timing slips show up.
  always @(posedge clk) begin
    rd_data_a <= rd_en_a ? mem[rd_addr_a[5:0]] : 8'hxx;
    rd_data_b <= rd_en_b ? mem[rd_addr_b[5:0]] : 8'hxx;
  end

  int          checks = 0;
  int          errors = 0;
  int          exp_rd_a[$];
  int          exp_rd_b[$];
  logic [23:0] exp_out_a[$];
  logic [23:0] exp_out_b[$];
  int          rd_cnt_a = 0, rd_cnt_b = 0;
  int          first_rd_a = -1, first_ov_a = -1;
  int          t0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  function automatic bit gt(input logic [7:0] v, input logic [7:0] m);
`ifdef MAXPOOL_SIGNED_EN
    return $signed(v) > $signed(m);
`else
    return v > m;
`endif
  endfunction

  task automatic expect_run(input int sel, input int ih, input int iw, input int ch,
                            input int p, input int s);
    int oh_n, ow_n, r, col, a, oa;
    logic [7:0] mx, v;
    bit first;
    oh_n = ih / s;
    ow_n = iw / s;
    for (int c = 0; c < ch; c++)
      for (int oh = 0; oh < oh_n; oh++)
        for (int ow = 0; ow < ow_n; ow++) begin
          first = 1'b1;
          mx    = 8'h00;
          for (int i = 0; i < p; i++)
            for (int j = 0; j < p; j++) begin
              r   = oh * s + i;
              col = ow * s + j;
              if (r < ih && col < iw) begin
                a = c * ih * iw + r * iw + col;
                v = mem[a];
                if (sel == 0) exp_rd_a.push_back(a);
                else exp_rd_b.push_back(a);
                if (first || gt(v, mx)) mx = v;
                first = 1'b0;
              end
            end
          oa = c * oh_n * ow_n + oh * ow_n + ow;
          if (sel == 0) exp_out_a.push_back({16'(oa), mx});
          else exp_out_b.push_back({16'(oa), mx});
        end
  endtask

  always @(negedge clk) begin
    if (rd_en_a) begin
      rd_cnt_a++;
      if (first_rd_a < 0) first_rd_a = cyc;
      if (exp_rd_a.size() == 0) check("rd_a_unexpected", 32'(rd_addr_a), 32'hffff_ffff);
      else check("rd_addr_a", 32'(rd_addr_a), exp_rd_a.pop_front());
    end
    if (out_valid_a && first_ov_a < 0) first_ov_a = cyc;
    if (out_valid_a && out_ready_a) begin
      if (exp_out_a.size() == 0)
        check("out_a_unexpected", 32'({out_addr_a, out_data_a}), 32'hffff_ffff);
      else check("out_a_addr_data", 32'({out_addr_a, out_data_a}), 32'(exp_out_a.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rd_en_b) begin
      rd_cnt_b++;
      if (exp_rd_b.size() == 0) check("rd_b_unexpected", 32'(rd_addr_b), 32'hffff_ffff);
      else check("rd_addr_b", 32'(rd_addr_b), exp_rd_b.pop_front());
    end
    if (out_valid_b && out_ready_b) begin
      if (exp_out_b.size() == 0)
        check("out_b_unexpected", 32'({out_addr_b, out_data_b}), 32'hffff_ffff);
      else check("out_b_addr_data", 32'({out_addr_b, out_data_b}), 32'(exp_out_b.pop_front()));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int sel, input string tag);
    int k = 0;
    while (!(sel == 0 ? done_a : done_b) && k < 300) begin
      cycle();
      k++;
    end
    check(tag, 32'(sel == 0 ? done_a : done_b), 1);
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_busy"}, 32'(busy_a), 0);
    check({tag, "_done"}, 32'(done_a), 0);
    check({tag, "_rd_en"}, 32'(rd_en_a), 0);
    check({tag, "_out_valid"}, 32'(out_valid_a), 0);
    check({tag, "_rd_addr"}, 32'(rd_addr_a), 0);
    check({tag, "_out_addr"}, 32'(out_addr_a), 0);
    check({tag, "_out_data"}, 32'(out_data_a), 0);
  endtask

  task automatic start_a_pulse();
    start_a = 1'b1;
    t0 = cyc;
    cycle();
    start_a = 1'b0;
  endtask

  task automatic queues_empty_a(input string tag);
    check({tag, "_rd_left"}, exp_rd_a.size(), 0);
    check({tag, "_out_left"}, exp_out_a.size(), 0);
  endtask

  initial begin
    int k;
    for (int n = 0; n < 64; n++) mem[n] = 8'(n);

    // Reset state
    rst = 1'b1;
    cycle();
    cycle();
    check_idle_a("reset");
    check("reset_b_busy", 32'(busy_b), 0);
    check("reset_b_rd_en", 32'(rd_en_b), 0);
    rst = 1'b0;
    cycle();

    // Nominal run with starts while busy and during DONE
    expect_run(0, 4, 4, 1, 2, 2);
    rd_cnt_a = 0;
    first_rd_a = -1;
    first_ov_a = -1;
    start_a_pulse();
    check("run1_busy", 32'(busy_a), 1);
    cycle();
    start_a = 1'b1;
    cycle();
    start_a = 1'b0;
    while (cyc < t0 + 25) cycle();
    check("run1_done_at_25", 32'(done_a), 1);
    check("run1_busy_in_done", 32'(busy_a), 0);
    start_a = 1'b1;
    cycle();
    start_a = 1'b0;
    repeat (8) cycle();
    check("run1_first_rd_cycle", first_rd_a - t0, 1);
    check("run1_first_ov_cycle", first_ov_a - t0, 6);
    check("run1_rd_count", rd_cnt_a, 16);
    check("run1_idle_after", 32'(busy_a), 0);
    queues_empty_a("run1");

    // Back-pressure on the first output
    expect_run(0, 4, 4, 1, 2, 2);
    out_ready_a = 1'b0;
    start_a_pulse();
    k = 0;
    while (!out_valid_a && k < 50) begin
      cycle();
      k++;
    end
    for (int n = 0; n < 3; n++) begin
      check("stall_valid", 32'(out_valid_a), 1);
      check("stall_data", 32'(out_data_a), 5);
      check("stall_addr", 32'(out_addr_a), 0);
      check("stall_no_rd", 32'(rd_en_a), 0);
      cycle();
    end
    check("stall_valid_end", 32'(out_valid_a), 1);
    out_ready_a = 1'b1;
    wait_done(0, "run2_done");
    cycle();
    queues_empty_a("run2");

    // Reset during the second window's reads
    expect_run(0, 4, 4, 1, 2, 2);
    start_a_pulse();
    while (cyc < t0 + 8) cycle();
    check("midrst_rd_en", 32'(rd_en_a), 1);
    check("midrst_rd_addr", 32'(rd_addr_a), 3);
    rst = 1'b1;
    #1;
    check_idle_a("midrst_async");
    cycle();
    check_idle_a("midrst");
    exp_rd_a.delete();
    exp_out_a.delete();
    rst = 1'b0;
    repeat (5) cycle();
    check("midrst_quiet", 32'(out_valid_a), 0);
    expect_run(0, 4, 4, 1, 2, 2);
    start_a_pulse();
    wait_done(0, "run3_done");
    cycle();
    queues_empty_a("run3");

    // Sign-sensitive window
    mem[0] = 8'hff;
    mem[1] = 8'h01;
    mem[4] = 8'h00;
    mem[5] = 8'h7f;
    expect_run(0, 4, 4, 1, 2, 2);
    start_a_pulse();
    k = 0;
    while (!out_valid_a && k < 50) begin
      cycle();
      k++;
    end
`ifdef MAXPOOL_SIGNED_EN
    check("signed_window", 32'(out_data_a), 32'h7f);
`else
    check("unsigned_window", 32'(out_data_a), 32'hff);
`endif
    wait_done(0, "run4_done");
    cycle();
    queues_empty_a("run4");

    // Two channels, 3x3 windows clipped at the map edge
    for (int n = 0; n < 32; n++) mem[n] = 8'((n * 37 + 11) & 255);
    expect_run(1, 4, 4, 2, 3, 2);
    rd_cnt_b = 0;
    start_b = 1'b1;
    cycle();
    start_b = 1'b0;
    wait_done(1, "runb_done");
    cycle();
    check("runb_rd_count", rd_cnt_b, 50);
    check("runb_rd_left", exp_rd_b.size(), 0);
    check("runb_out_left", exp_out_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
